pc_jump_unit: RTL and testbench

Program counter and jump-condition stage of the HACK CPU. It sits directly downstream of the ALU flag outputs (`zr`, `ng`) and the gate-level combinational logic. It evaluates the C-instruction jump bits against those flags, then registers the next instruction address that feeds the instruction ROM. It also detects the canonical HACK end-of-program self-loop, raising a sticky `halted` flag, and keeps a saturating retired-instruction counter for debug.

---
 rtl/pc_jump_unit.sv | 101 ++++++++++
 tb/tb_pc_jump_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pc_jump_unit.sv
// HACK CPU program counter / jump-condition stage: evaluates jump bits against ALU flags,
// registers the next ROM address, latches a sticky self-loop halt and counts retired cycles.
module pc_jump_unit #(
    parameter int WIDTH      = 15,
    parameter int RESET_ADDR = 0,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [15:0]          instr,
    input  logic [15:0]          a_reg,
    input  logic                 zr,
    input  logic                 ng,
    output logic [WIDTH-1:0]     pc,
    output logic                 jump_taken,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] retired
);

    localparam logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_ADDR);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     pc_q, pc_d;
    logic [CNT_WIDTH-1:0] retired_q, retired_d;

    logic                 cond;
    logic [WIDTH-1:0]     target;
    logic                 self_loop;
    logic                 unused_bits;

    function automatic logic andGate(input logic a, input logic b);
        return a & b;
    endfunction

    function automatic logic orGate(input logic a, input logic b);
        return a | b;
    endfunction

    function automatic logic notGate(input logic a);
        return ~a;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Jump condition as a gate netlist: JLT | JEQ | JGT, qualified by the C-instruction bit.
    always_comb begin
        logic n_ng, n_zr, lt, eq, gt, any_hit;
        n_ng    = notGate(ng);
        n_zr    = notGate(zr);
        lt      = andGate(instr[2], ng);
        eq      = andGate(instr[1], zr);
        gt      = andGate(instr[0], andGate(n_ng, n_zr));
        any_hit = orGate(orGate(lt, eq), gt);
        cond    = andGate(instr[15], any_hit);
    end

    assign target     = a_reg[WIDTH-1:0];
    assign jump_taken = cond & en & (state_q == RUN) & ~reset;
    // The pc compare only decides the halt transition; it never reaches jump_taken.
    assign self_loop  = (target == pc_q);

    always_comb begin
        pc_d      = pc_q;
        retired_d = retired_q;
        state_d   = state_q;
        if (state_q == RUN && en) begin
            pc_d      = jump_taken ? target : pc_q + 1'b1;
            retired_d = sat_inc(retired_q);
            if (jump_taken && self_loop) begin
                state_d = HALT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
        end
    end

    assign pc      = pc_q;
    assign halted  = (state_q == HALT);
    assign retired = retired_q;

    assign unused_bits = ^{instr[14:3], a_reg >> WIDTH};

endmodule

// File: tb/tb_pc_jump_unit.sv
// Directed bench for pc_jump_unit: default-width instance plus a 4-bit instance for wrap/saturation.
module tb_pc_jump_unit;

    logic        clk;
    logic        reset, en, zr, ng;
    logic [15:0] instr, a_reg;
    logic [14:0] pc;
    logic        jump_taken, halted;
    logic [31:0] retired;

    logic        reset4, en4, zr4, ng4;
    logic [15:0] instr4, a_reg4;
    logic [3:0]  pc4;
    logic        jt4, halted4;
    logic [3:0]  retired4;

    int asserts  = 0;
    int failures = 0;
    logic [14:0] mpc;
    // Hand-derived take masks per jump code; bit0=(zr,ng)=(0,0), bit1=(1,0), bit2=(0,1).
    logic [2:0] jmask [8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};

    pc_jump_unit dut (
        .clk(clk), .reset(reset), .en(en), .instr(instr), .a_reg(a_reg), .zr(zr), .ng(ng),
        .pc(pc), .jump_taken(jump_taken), .halted(halted), .retired(retired)
    );

    pc_jump_unit #(.WIDTH(4), .RESET_ADDR(0), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset4), .en(en4), .instr(instr4), .a_reg(a_reg4), .zr(zr4), .ng(ng4),
        .pc(pc4), .jump_taken(jt4), .halted(halted4), .retired(retired4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; en = 1; instr = 16'hE307; a_reg = 16'h0100; zr = 0; ng = 0;
        reset4 = 1; en4 = 0; instr4 = 16'h0000; a_reg4 = 16'h0000; zr4 = 0; ng4 = 0;
        #1;
        asserts++; if (jump_taken !== 1'b0) begin failures++; $display("FAIL reset_jt: got %b expected 0", jump_taken); end
        step();
        asserts++; if (pc !== 15'h0) begin failures++; $display("FAIL reset_pc: got %0h expected 0", pc); end
        asserts++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted: got %b expected 0", halted); end
        asserts++; if (retired !== 32'd0) begin failures++; $display("FAIL reset_retired: got %0d expected 0", retired); end
        asserts++; if (jump_taken !== 1'b0) begin failures++; $display("FAIL reset_jt_held: got %b expected 0", jump_taken); end
        reset = 0; reset4 = 0; en = 0;
    endtask

    task automatic test_free_run();
        en = 1; instr = 16'h0005;
        for (int i = 1; i <= 3; i++) begin
            step();
            asserts++; if (pc !== 15'(i)) begin failures++; $display("FAIL free_pc[%0d]: got %0h expected %0h", i, pc, i); end
            asserts++; if (retired !== 32'(i)) begin failures++; $display("FAIL free_retired[%0d]: got %0d expected %0d", i, retired, i); end
            asserts++; if (jump_taken !== 1'b0) begin failures++; $display("FAIL free_jt[%0d]: got %b expected 0", i, jump_taken); end
            asserts++; if (halted !== 1'b0) begin failures++; $display("FAIL free_halted[%0d]: got %b expected 0", i, halted); end
        end
        mpc = 15'd3;
    endtask

    task automatic test_jump_matrix();
        logic take;
        en = 1; a_reg = 16'h0100;
        for (int code = 1; code <= 7; code++) begin
            for (int f = 0; f < 3; f++) begin
                zr = (f == 1); ng = (f == 2);
                instr = 16'hE300 | 16'(code);
                take = jmask[code][f];
                #1;
                asserts++; if (jump_taken !== take) begin failures++; $display("FAIL matrix_jt code=%0d f=%0d: got %b expected %b", code, f, jump_taken, take); end
                step();
                mpc = take ? 15'h0100 : mpc + 1'b1;
                asserts++; if (pc !== mpc) begin failures++; $display("FAIL matrix_pc code=%0d f=%0d: got %0h expected %0h", code, f, pc, mpc); end
                instr = 16'h0007;
                #1;
                asserts++; if (jump_taken !== 1'b0) begin failures++; $display("FAIL matrix_ainstr_jt code=%0d f=%0d: got %b expected 0", code, f, jump_taken); end
                step();
                mpc = mpc + 1'b1;
                asserts++; if (pc !== mpc) begin failures++; $display("FAIL matrix_ainstr_pc code=%0d f=%0d: got %0h expected %0h", code, f, pc, mpc); end
            end
        end
        zr = 0; ng = 0;
    endtask

    task automatic test_upper_bits();
        en = 1; instr = 16'hE307; a_reg = 16'hC123;
        step();
        asserts++; if (pc !== 15'h4123) begin failures++; $display("FAIL upper_bits_pc: got %0h expected 4123", pc); end
        asserts++; if (halted !== 1'b0) begin failures++; $display("FAIL upper_bits_halted: got %b expected 0", halted); end
    endtask

    task automatic test_back_to_back();
        en = 1; instr = 16'hE307; a_reg = 16'h0050;
        step();
        asserts++; if (pc !== 15'h0050) begin failures++; $display("FAIL b2b_pc0: got %0h expected 50", pc); end
        a_reg = 16'h0060;
        step();
        asserts++; if (pc !== 15'h0060) begin failures++; $display("FAIL b2b_pc1: got %0h expected 60", pc); end
        instr = 16'hE302; zr = 1; a_reg = 16'h0070;
        step();
        asserts++; if (pc !== 15'h0070) begin failures++; $display("FAIL b2b_pc2: got %0h expected 70", pc); end
        zr = 0;
    endtask

    task automatic test_stall();
        reset = 1; step(); reset = 0;
        en = 1; instr = 16'h0005;
        repeat (4) step();
        asserts++; if (pc !== 15'd4) begin failures++; $display("FAIL stall_setup_pc: got %0h expected 4", pc); end
        en = 0; instr = 16'hE307; a_reg = 16'h0100;
        for (int i = 0; i < 3; i++) begin
            #1;
            asserts++; if (jump_taken !== 1'b0) begin failures++; $display("FAIL stall_jt[%0d]: got %b expected 0", i, jump_taken); end
            step();
            asserts++; if (pc !== 15'd4) begin failures++; $display("FAIL stall_pc[%0d]: got %0h expected 4", i, pc); end
            asserts++; if (retired !== 32'd4) begin failures++; $display("FAIL stall_retired[%0d]: got %0d expected 4", i, retired); end
        end
        en = 1;
        #1;
        asserts++; if (jump_taken !== 1'b1) begin failures++; $display("FAIL stall_resume_jt: got %b expected 1", jump_taken); end
        step();
        asserts++; if (pc !== 15'h0100) begin failures++; $display("FAIL stall_resume_pc: got %0h expected 100", pc); end
        asserts++; if (retired !== 32'd5) begin failures++; $display("FAIL stall_resume_retired: got %0d expected 5", retired); end
    endtask

    task automatic test_wrap_saturate();
        en4 = 1;
        for (int i = 1; i <= 20; i++) begin
            step();
            asserts++; if (pc4 !== 4'(i)) begin failures++; $display("FAIL wrap_pc[%0d]: got %0d expected %0d", i, pc4, i % 16); end
            asserts++; if (retired4 !== ((i > 15) ? 4'd15 : 4'(i))) begin failures++; $display("FAIL sat_retired[%0d]: got %0d expected %0d", i, retired4, (i > 15) ? 15 : i); end
        end
        en4 = 0;
    endtask

    task automatic test_halt();
        reset = 1; step(); reset = 0;
        en = 1; instr = 16'h0005;
        repeat (10) step();
        asserts++; if (pc !== 15'h000A) begin failures++; $display("FAIL halt_setup_pc: got %0h expected a", pc); end
        instr = 16'hEA87; a_reg = 16'h000A; zr = 0; ng = 0;
        #1;
        asserts++; if (jump_taken !== 1'b1) begin failures++; $display("FAIL halt_jt: got %b expected 1", jump_taken); end
        step();
        asserts++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_flag: got %b expected 1", halted); end
        asserts++; if (pc !== 15'h000A) begin failures++; $display("FAIL halt_pc: got %0h expected a", pc); end
        asserts++; if (retired !== 32'd11) begin failures++; $display("FAIL halt_retired: got %0d expected 11", retired); end
        instr = 16'hE307; a_reg = 16'h0020;
        for (int i = 0; i < 3; i++) begin
            en = (i != 1);
            #1;
            asserts++; if (jump_taken !== 1'b0) begin failures++; $display("FAIL halted_jt[%0d]: got %b expected 0", i, jump_taken); end
            step();
            asserts++; if (pc !== 15'h000A) begin failures++; $display("FAIL halted_pc[%0d]: got %0h expected a", i, pc); end
            asserts++; if (retired !== 32'd11) begin failures++; $display("FAIL halted_retired[%0d]: got %0d expected 11", i, retired); end
            asserts++; if (halted !== 1'b1) begin failures++; $display("FAIL halted_sticky[%0d]: got %b expected 1", i, halted); end
        end
    endtask

    task automatic test_reset_mid_halt();
        reset = 1; en = 1;
        #1;
        asserts++; if (jump_taken !== 1'b0) begin failures++; $display("FAIL rst_halt_jt: got %b expected 0", jump_taken); end
        step();
        asserts++; if (pc !== 15'h0) begin failures++; $display("FAIL rst_halt_pc: got %0h expected 0", pc); end
        asserts++; if (halted !== 1'b0) begin failures++; $display("FAIL rst_halt_flag: got %b expected 0", halted); end
        asserts++; if (retired !== 32'd0) begin failures++; $display("FAIL rst_halt_retired: got %0d expected 0", retired); end
        reset = 0; instr = 16'h0005;
        for (int i = 1; i <= 2; i++) begin
            step();
            asserts++; if (pc !== 15'(i)) begin failures++; $display("FAIL rst_resume_pc[%0d]: got %0h expected %0h", i, pc, i); end
            asserts++; if (retired !== 32'(i)) begin failures++; $display("FAIL rst_resume_retired[%0d]: got %0d expected %0d", i, retired, i); end
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_jump_matrix();
        test_upper_bits();
        test_back_to_back();
        test_stall();
        test_wrap_saturate();
        test_halt();
        test_reset_mid_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
